// File: rtl/ypb_tcm_responder_if.sv
// YPB request/response channel between a pipeline-side initiator and a responder.
interface ypb_tcm_responder_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) ();
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_we;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [ID_WIDTH-1:0]     req_id;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic [ID_WIDTH-1:0]     rsp_id;
  logic                    rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_be, req_wdata, req_id, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_wdata, req_id, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_id, rsp_err
  );
endinterface

// File: rtl/ypb_tcm_responder.sv
// Tightly-coupled memory acting as a YPB responder: array access at accept,
// fixed-latency stage chain, in-order response FIFO and a credit counter that
// keeps the FIFO from ever overflowing.
module ypb_tcm_responder #(
  parameter int          DATA_WIDTH     = 64,
  parameter int          ADDR_WIDTH     = 64,
  parameter int          ID_WIDTH       = 4,
  parameter int          DEPTH_WORDS    = 1024,
  parameter logic [63:0] BASE_ADDR      = 64'h8000_0000,
  parameter int          LATENCY        = 2,
  parameter int          RSP_FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ypb_tcm_responder_if.slave  bus
);
  localparam int BE_W     = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BE_W);
  localparam int IDX_W    = $clog2(DEPTH_WORDS);
  localparam int TAG_LSB  = OFF_BITS + IDX_W;
  localparam int CNT_W    = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int PTR_W    = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic [ID_WIDTH-1:0]   id;
    logic                  err;
  } entry_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [CNT_W-1:0]      outstanding_q;
  logic                  accept;
  logic                  pop;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  entry_t                acc_entry;
  entry_t                push_entry;
  logic                  push_vld;
  logic                  unused_addr_bits;

  // The base is aligned to the array size, so the range check is a tag compare.
  assign in_range         = (bus.req_addr[ADDR_WIDTH-1:TAG_LSB] == BASE_ADDR[ADDR_WIDTH-1:TAG_LSB]);
  assign idx              = bus.req_addr[TAG_LSB-1:OFF_BITS];
  assign unused_addr_bits = ^bus.req_addr[OFF_BITS-1:0];

  // Grant depends only on the credit register and reset, never on valid/ready inputs.
  assign bus.req_ready = !rst_i && (outstanding_q < CNT_W'(RSP_FIFO_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;

  // Build the response entry from the word read at accept time.
  always_comb begin
    // NOTE: assign every field a default first so no path leaves a latch behind.
    acc_entry     = '0;
    acc_entry.id  = bus.req_id;
    acc_entry.err = !in_range;
    if (in_range && !bus.req_we) acc_entry.rdata = mem[idx];
  end

  // Byte-merged write into the array on an in-range accepted store.
  // NOTE: the array has no reset branch; contents survive reset and stay RAM-inferable.
  always_ff @(posedge clk_i) begin
    if (accept && in_range && bus.req_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.req_be[b]) mem[idx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
      end
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign push_vld   = accept;
      assign push_entry = acc_entry;
    end else begin : g_stages
      entry_t               stg_q [LATENCY-1];
      logic [LATENCY-2:0]   stg_vld_q;

      // Non-stalling valid chain; reset drops every in-flight entry.
      always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
        if (rst_i) begin
          stg_vld_q <= '0;
        end else begin
          stg_vld_q[0] <= accept;
          for (int i = 1; i < LATENCY - 1; i++) stg_vld_q[i] <= stg_vld_q[i-1];
        end
      end

      // Payload shifts every cycle; the valid chain qualifies it.
      always_ff @(posedge clk_i) begin
        stg_q[0] <= acc_entry;
        for (int i = 1; i < LATENCY - 1; i++) stg_q[i] <= stg_q[i-1];
      end

      assign push_vld   = stg_vld_q[LATENCY-2];
      assign push_entry = stg_q[LATENCY-2];
    end
  endgenerate

  entry_t           fifo_q [RSP_FIFO_DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // FIFO pointers and fill level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_vld) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)      rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push_vld) - CNT_W'(pop);
    end
  end

  // FIFO storage; pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_vld) fifo_q[wr_ptr_q] <= push_entry;
  end

  // Credits cover both the stage chain and the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) outstanding_q <= '0;
    else       outstanding_q <= outstanding_q + CNT_W'(accept) - CNT_W'(pop);
  end

  assign head          = fifo_q[rd_ptr_q];
  assign bus.rsp_valid = (count_q != '0);
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_rdata = bus.rsp_valid ? head.rdata : '0;
  assign bus.rsp_id    = bus.rsp_valid ? head.id    : '0;
  assign bus.rsp_err   = bus.rsp_valid ? head.err   : 1'b0;
endmodule
